// File: rtl/alu_pkg.sv
// Shared definitions for the byte ALU: opcode encoding and width constants.
// Ports: none (package only).
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int RES_W = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NAND = 4'd7,
        OP_NOR  = 4'd8,
        OP_XNOR = 4'd9,
        OP_NOT  = 4'd10,
        OP_SHL  = 4'd11,
        OP_SHR  = 4'd12,
        OP_ROL  = 4'd13,
        OP_ROR  = 4'd14,
        OP_CMP  = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational result function of the byte ALU.
// Ports:
//   a, b  in  8  : unsigned operands
//   oper  in  4  : opcode (alu_op_e encoding)
//   res   out 16 : full 16-bit result, {high byte, low byte}
module alu_comb
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [3:0]       oper,
    output logic [RES_W-1:0] res
);

    logic [ALU_W-1:0] w_quot;
    logic [ALU_W-1:0] w_rem;
    logic [ALU_W-1:0] w_cmp;

    // Divide by zero returns an all-ones quotient and passes a through as
    // the remainder, so the divider never sees a zero divisor.
    always_comb begin
        w_quot = 8'hFF;
        w_rem  = a;
        if (b != 8'h00) begin
            w_quot = a / b;
            w_rem  = a % b;
        end
    end

    assign w_cmp = {5'b00000, (a > b), (a == b), (a < b)};

    always_comb begin
        res = '0;
        case (alu_op_e'(oper))
            OP_ADD:  res = {8'h00, a} + {8'h00, b};
            // Zero-extended 16-bit subtract: a < b borrows into msb = FF.
            OP_SUB:  res = {8'h00, a} - {8'h00, b};
            OP_MUL:  res = {8'h00, a} * {8'h00, b};
            OP_DIV:  res = {w_rem, w_quot};
            OP_AND:  res = {8'h00, a & b};
            OP_OR:   res = {8'h00, a | b};
            OP_XOR:  res = {8'h00, a ^ b};
            OP_NAND: res = {8'h00, ~(a & b)};
            OP_NOR:  res = {8'h00, ~(a | b)};
            OP_XNOR: res = {8'h00, ~(a ^ b)};
            OP_NOT:  res = {8'h00, ~a};
            // a[7] shifts out into bit 8 of the result.
            OP_SHL:  res = {7'h00, a, 1'b0};
            OP_SHR:  res = {8'h00, 1'b0, a[7:1]};
            OP_ROL:  res = {8'h00, a[6:0], a[7]};
            OP_ROR:  res = {8'h00, a[0], a[7:1]};
            OP_CMP:  res = {8'h00, w_cmp};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered 8-bit ALU with a 16-bit result split into msb/lsb bytes.
// Operands and opcode are sampled every rising edge; result appears one
// cycle later. Synchronous active-high reset clears both output bytes.
// Ports:
//   clk   in  1 : rising-edge clock
//   rst   in  1 : synchronous active-high reset
//   a, b  in  8 : unsigned operands
//   oper  in  4 : opcode (alu_op_e encoding)
//   msb   out 8 : registered result bits [15:8]
//   lsb   out 8 : registered result bits [7:0]
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [3:0]       oper,
    output logic [ALU_W-1:0] msb,
    output logic [ALU_W-1:0] lsb
);

    logic [RES_W-1:0] w_res;
    logic [ALU_W-1:0] r_msb;
    logic [ALU_W-1:0] r_lsb;

    alu_comb u_comb (
        .a    (a),
        .b    (b),
        .oper (oper),
        .res  (w_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msb <= 8'h00;
            r_lsb <= 8'h00;
        end else begin
            r_msb <= w_res[15:8];
            r_lsb <= w_res[7:0];
        end
    end

    assign msb = r_msb;
    assign lsb = r_lsb;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] oper;
    logic [7:0] msb;
    logic [7:0] lsb;

    int n_tests = 0;
    int n_fail  = 0;

    alu dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .oper (oper),
        .msb  (msb),
        .lsb  (lsb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a = 8'hFE; b = 8'h7F; oper = 4'd2; rst = 1'b1;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_edge1 got %h expected 0000", {msb, lsb});
        end
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_edge2 got %h expected 0000", {msb, lsb});
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'h7E02) begin
            n_fail++;
            $display("FAIL reset_release got %h expected 7E02", {msb, lsb});
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_tab [16];
        exp_tab = '{16'h017D, 16'h007F, 16'h7E02, 16'h0002,
                    16'h007E, 16'h00FF, 16'h0081, 16'h0081,
                    16'h0000, 16'h007E, 16'h0001, 16'h01FC,
                    16'h007F, 16'h00FD, 16'h007F, 16'h0004};
        a = 8'hFE; b = 8'h7F;
        for (int i = 0; i < 16; i++) begin
            oper = 4'(i);
            tick();
            n_tests++;
            if ({msb, lsb} !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL sweep_op%0d got %h expected %h", i, {msb, lsb}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        a = 8'hFF; b = 8'hFF; oper = 4'd0;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'h01FE) begin
            n_fail++;
            $display("FAIL add_ff_ff got %h expected 01FE", {msb, lsb});
        end
        a = 8'h00; b = 8'h01; oper = 4'd1;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sub_00_01 got %h expected FFFF", {msb, lsb});
        end
        a = 8'hFF; b = 8'hFF; oper = 4'd2;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'hFE01) begin
            n_fail++;
            $display("FAIL mul_ff_ff got %h expected FE01", {msb, lsb});
        end
    endtask

    task automatic test_div_zero();
        a = 8'h37; b = 8'h00; oper = 4'd3;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'h37FF) begin
            n_fail++;
            $display("FAIL div_by_zero got %h expected 37FF", {msb, lsb});
        end
        b = 8'h05;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'h000B) begin
            n_fail++;
            $display("FAIL div_37_05 got %h expected 000B", {msb, lsb});
        end
    endtask

    task automatic test_cmp();
        a = 8'h42; b = 8'h42; oper = 4'd15;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'h0002) begin
            n_fail++;
            $display("FAIL cmp_eq got %h expected 0002", {msb, lsb});
        end
        a = 8'h01; b = 8'h80;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'h0001) begin
            n_fail++;
            $display("FAIL cmp_lt got %h expected 0001", {msb, lsb});
        end
    endtask

    // Operand/opcode change every cycle; each edge must expose exactly the
    // operation presented before it, and hold it through the next half cycle.
    task automatic test_back_to_back();
        logic [7:0]  ta [8];
        logic [7:0]  tb [8];
        logic [3:0]  top [8];
        logic [15:0] te [8];
        ta  = '{8'h12, 8'h50, 8'h10, 8'hC8, 8'hF0, 8'h81, 8'h81, 8'h81};
        tb  = '{8'h34, 8'h30, 8'h10, 8'h07, 8'h0F, 8'h00, 8'h55, 8'hAA};
        top = '{4'd0,  4'd1,  4'd2,  4'd3,  4'd6,  4'd14, 4'd13, 4'd11};
        te  = '{16'h0046, 16'h0020, 16'h0100, 16'h041C,
                16'h00FF, 16'h00C0, 16'h0003, 16'h0102};
        for (int i = 0; i < 8; i++) begin
            a = ta[i]; b = tb[i]; oper = top[i];
            tick();
            n_tests++;
            if ({msb, lsb} !== te[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d got %h expected %h", i, {msb, lsb}, te[i]);
            end
            // Present the next vector early; output must not follow it yet.
            if (i < 7) begin
                a = ta[i+1]; b = tb[i+1]; oper = top[i+1];
            end
            @(negedge clk);
            n_tests++;
            if ({msb, lsb} !== te[i]) begin
                n_fail++;
                $display("FAIL b2b_hold_%0d got %h expected %h", i, {msb, lsb}, te[i]);
            end
        end
        // Reset mid-stream overrides a live MUL.
        a = 8'hFF; b = 8'hFF; oper = 4'd2; rst = 1'b1;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'h0000) begin
            n_fail++;
            $display("FAIL midstream_reset got %h expected 0000", {msb, lsb});
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({msb, lsb} !== 16'hFE01) begin
            n_fail++;
            $display("FAIL after_midstream_reset got %h expected FE01", {msb, lsb});
        end
    endtask

    initial begin
        rst = 1'b1; a = 8'h00; b = 8'h00; oper = 4'd0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_boundaries();
        test_div_zero();
        test_cmp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
